axis_s2mm_ring_ctrl: RTL and testbench
======================================

Name: axis_s2mm_ring_ctrl

Overview:
Sequencing controller for the AXI-Stream-to-AXI-MM burst writer. It places consecutive stream transfers, each terminated by TLAST, into a ring of NUM_BUFS equally spaced memory buffers. For each transfer it programs the writer's base address, pulses its start, and waits for its done. It then hands the filled buffer index to a downstream consumer and tracks buffer ownership, so a buffer is never overwritten before the consumer releases it.

Parameters:
AXI_ADDR_WIDTH, 32, width of addresses driven to the writer
NUM_BUFS, 4, ring depth in buffers (2..16)
IDX_W, $clog2(NUM_BUFS), buffer index width
TIMEOUT_W, 24, width of the per-transfer watchdog counter

Ports:
ACLK  in  1  clock
ARESETn  in  1  synchronous active-low reset
cfg_enable  in  1  run ring when high
cfg_base_addr  in  AXI_ADDR_WIDTH  address of buffer 0
cfg_buf_stride  in  AXI_ADDR_WIDTH  byte distance between buffers
cfg_timeout  in  TIMEOUT_W  max RUN cycles per transfer; 0 disables the watchdog
wr_base_addr  out  AXI_ADDR_WIDTH  to writer BASE_ADDR
wr_start  out  1  to writer START
wr_busy  in  1  from writer BUSY
wr_done  in  1  from writer DONE (1-cycle pulse)
cmp_valid  out  1  completed buffer available
cmp_idx  out  IDX_W  completed buffer index
cmp_ready  in  1  consumer accepts completion
rel_valid  in  1  consumer releases buffer (1-cycle)
rel_idx  in  IDX_W  released buffer index
owned_mask  out  NUM_BUFS  bit i = buffer i held by consumer
ctrl_busy  out  1  state != IDLE
timeout_err  out  1  sticky watchdog error
rel_err  out  1  sticky bad-release error
stall_cnt  out  16  saturating count of SELECT cycles blocked on an owned buffer

Behaviour:
- Reset (ARESETn=0 at a rising edge of ACLK):
  - state=IDLE, wr_idx=0.
  - All outputs 0: wr_base_addr, wr_start, cmp_valid, cmp_idx, owned_mask, timeout_err, rel_err, stall_cnt.
  - Reset mid-transfer does not abort the writer; the writer is reset by the same ARESETn.
- States: IDLE, SELECT, ARM, RUN, COMPLETE, HALT.
- IDLE: go to SELECT when cfg_enable=1. wr_idx is retained across disable and cleared only by reset.
- SELECT:
  - If cfg_enable=0, go to IDLE.
  - Else if owned_mask[wr_idx]=1, stay and increment stall_cnt (saturates at 0xFFFF).
  - Else register wr_base_addr = cfg_base_addr + wr_idx*cfg_buf_stride (modulo 2^AXI_ADDR_WIDTH), set wr_start=1 and go to ARM.
- ARM:
  - wr_start is held high until wr_busy=1 is sampled.
  - On that edge, clear wr_start, clear the watchdog counter and go to RUN.
  - The writer only leaves its idle when stream data is valid, so ARM may last indefinitely; cfg_enable is ignored in ARM.
- RUN:
  - wr_base_addr is stable from ARM entry until the transfer completes.
  - The watchdog counter increments each cycle.
  - On wr_done=1, go to COMPLETE and set cmp_valid=1, cmp_idx=wr_idx.
  - Else, if cfg_timeout!=0 and counter==cfg_timeout, set timeout_err and go to HALT.
  - If wr_done and expiry occur in the same cycle, wr_done wins.
- COMPLETE:
  - cmp_valid/cmp_idx are held stable until cmp_ready=1.
  - On the cmp_valid & cmp_ready handshake: clear cmp_valid, set owned_mask[cmp_idx], set wr_idx = (wr_idx==NUM_BUFS-1) ? 0 : wr_idx+1, and go to SELECT.
  - Handshake latency is 0 cycles when cmp_ready is already high.
- HALT: wr_start=0, ctrl_busy=1. Leave to IDLE only when cfg_enable=0. timeout_err is cleared only by reset.
- Release handling, evaluated every cycle in every state:
  - rel_valid with owned_mask[rel_idx]=1 clears that bit.
  - rel_valid with owned_mask[rel_idx]=0, or rel_idx>=NUM_BUFS, sets rel_err and leaves the mask unchanged.
  - A release and a completion set in the same cycle both apply.
  - If a release and a completion set target the same index, the release is an error (bit not yet owned) and the set wins.
- Minimum turnaround from wr_done to the next wr_start is 2 cycles (COMPLETE with cmp_ready=1, then SELECT).

Test Plan:
- Basic ring, NUM_BUFS=4, base=0x1000_0000, stride=0x400, cmp_ready=1, consumer releases each index 5 cycles after cmp -> wr_base_addr sequence 0x10000000, 0x10000400, 0x10000800, 0x10000C00, 0x10000000; cmp_idx 0,1,2,3,0; stall_cnt=0.
- No releases, 5 transfers offered -> 4 completions, then stuck in SELECT with owned_mask=4'b1111 and stall_cnt counting; release idx 0 -> next wr_base_addr=0x10000000 within 2 cycles.
- cmp_ready held low 10 cycles after wr_done -> cmp_valid/cmp_idx stable for 10 cycles, no new wr_start, owned bit set only at the handshake.
- cfg_timeout=50, writer stalled by wready=0 -> timeout_err=1 at RUN cycle 50, state HALT; cfg_enable=0 -> IDLE.
- rel_valid for an unowned index, and a release coinciding with the completion of the same index -> rel_err=1, owned bit set.
- Address wrap: base=0xFFFF_F800, stride=0x400 -> buffer 2 address 0x0000_0000.
- Disable during SELECT -> IDLE next cycle with wr_start never asserted; re-enable resumes at the retained wr_idx.

Source files
------------

// File: rtl/axis_s2mm_ring_ctrl_if.sv
// ---------------------------------------------------------------------------
// axis_s2mm_ring_ctrl_if
// Bundles the ring controller's two handshake groups:
//   writer side    : wr_base_addr, wr_start (to writer); wr_busy, wr_done (from writer)
//   consumer side  : cmp_valid, cmp_idx (to consumer); cmp_ready (from consumer)
//                    rel_valid, rel_idx (consumer hands a buffer back)
// Modports:
//   master : the ring controller
//   slave  : the writer / consumer / testbench side
// ---------------------------------------------------------------------------
interface axis_s2mm_ring_ctrl_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int NUM_BUFS       = 4,
    parameter int IDX_W          = $clog2(NUM_BUFS)
);
    logic [AXI_ADDR_WIDTH-1:0] wr_base_addr;
    logic                      wr_start;
    logic                      wr_busy;
    logic                      wr_done;

    logic                      cmp_valid;
    logic [IDX_W-1:0]          cmp_idx;
    logic                      cmp_ready;

    logic                      rel_valid;
    logic [IDX_W-1:0]          rel_idx;

    modport master (
        output wr_base_addr,
        output wr_start,
        input  wr_busy,
        input  wr_done,
        output cmp_valid,
        output cmp_idx,
        input  cmp_ready,
        input  rel_valid,
        input  rel_idx
    );

    modport slave (
        input  wr_base_addr,
        input  wr_start,
        output wr_busy,
        output wr_done,
        input  cmp_valid,
        input  cmp_idx,
        output cmp_ready,
        output rel_valid,
        output rel_idx
    );
endinterface

// File: rtl/axis_s2mm_ring_ctrl.sv
// ---------------------------------------------------------------------------
// axis_s2mm_ring_ctrl
// Sequences the AXI-Stream-to-AXI-MM burst writer over a ring of NUM_BUFS
// equally spaced buffers. Each TLAST-terminated transfer gets its own buffer:
// the controller programs the buffer base address, pulses the writer start,
// waits for done, then offers the buffer index to a consumer. A buffer handed
// to the consumer stays owned (never rewritten) until the consumer releases it.
//
// Ports:
//   ACLK, ARESETn     clock, synchronous active-low reset
//   cfg_enable        run the ring while high
//   cfg_base_addr     address of buffer 0
//   cfg_buf_stride    byte distance between consecutive buffers
//   cfg_timeout       max RUN cycles per transfer, 0 disables the watchdog
//   bus (master)      writer handshake + completion/release handshakes
//   owned_mask        bit i set while buffer i is held by the consumer
//   ctrl_busy         controller is not IDLE
//   timeout_err       sticky watchdog error
//   rel_err           sticky bad-release error
//   stall_cnt         saturating count of SELECT cycles blocked by ownership
// ---------------------------------------------------------------------------
module axis_s2mm_ring_ctrl #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int NUM_BUFS       = 4,
    parameter int IDX_W          = $clog2(NUM_BUFS),
    parameter int TIMEOUT_W      = 24
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic                      cfg_enable,
    input  logic [AXI_ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] cfg_buf_stride,
    input  logic [TIMEOUT_W-1:0]      cfg_timeout,
    axis_s2mm_ring_ctrl_if.master     bus,
    output logic [NUM_BUFS-1:0]       owned_mask,
    output logic                      ctrl_busy,
    output logic                      timeout_err,
    output logic                      rel_err,
    output logic [15:0]               stall_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_ARM      = 3'd2,
        ST_RUN      = 3'd3,
        ST_COMPLETE = 3'd4,
        ST_HALT     = 3'd5
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BUFS - 1);
    localparam logic [IDX_W:0]   NUM_BUFS_W = (IDX_W + 1)'(NUM_BUFS);

    // Next ring slot, wrapping after the last buffer.
    function automatic logic [IDX_W-1:0] ring_next(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx == LAST_IDX) begin
            nxt = {IDX_W{1'b0}};
        end else begin
            nxt = idx + IDX_W'(1);
        end
        return nxt;
    endfunction

    // Buffer address; the product and sum wrap modulo 2^AXI_ADDR_WIDTH.
    function automatic logic [AXI_ADDR_WIDTH-1:0] buf_addr(
        input logic [AXI_ADDR_WIDTH-1:0] base,
        input logic [AXI_ADDR_WIDTH-1:0] stride,
        input logic [IDX_W-1:0]          idx
    );
        logic [AXI_ADDR_WIDTH-1:0] offset;
        offset = AXI_ADDR_WIDTH'(idx) * stride;
        return base + offset;
    endfunction

    // One-hot decode of a buffer index into the ownership mask layout.
    function automatic logic [NUM_BUFS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_BUFS-1:0] oh;
        oh      = {NUM_BUFS{1'b0}};
        oh[idx] = 1'b1;
        return oh;
    endfunction

    state_t                    state_r,       state_nxt_s;
    logic [IDX_W-1:0]          wr_idx_r,      wr_idx_nxt_s;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr_r,     wr_addr_nxt_s;
    logic                      wr_start_r,    wr_start_nxt_s;
    logic                      cmp_valid_r,   cmp_valid_nxt_s;
    logic [IDX_W-1:0]          cmp_idx_r,     cmp_idx_nxt_s;
    logic [TIMEOUT_W-1:0]      wd_cnt_r,      wd_cnt_nxt_s;
    logic [TIMEOUT_W-1:0]      wd_inc_s;
    logic [15:0]               stall_cnt_r,   stall_cnt_nxt_s;
    logic                      timeout_err_r, timeout_err_nxt_s;
    logic                      rel_err_r,     rel_err_nxt_s;
    logic [NUM_BUFS-1:0]       owned_r,       owned_nxt_s;
    logic                      ctrl_busy_r;

    logic                      cmp_set_s;
    logic                      rel_in_range_s;
    logic                      rel_owned_s;
    logic [NUM_BUFS-1:0]       clr_mask_s;
    logic [NUM_BUFS-1:0]       set_mask_s;

    // Ring sequencing: next state plus next values of every FSM-owned register.
    always_comb begin
        state_nxt_s       = state_r;
        wr_idx_nxt_s      = wr_idx_r;
        wr_addr_nxt_s     = wr_addr_r;
        wr_start_nxt_s    = wr_start_r;
        cmp_valid_nxt_s   = cmp_valid_r;
        cmp_idx_nxt_s     = cmp_idx_r;
        wd_cnt_nxt_s      = wd_cnt_r;
        stall_cnt_nxt_s   = stall_cnt_r;
        timeout_err_nxt_s = timeout_err_r;
        cmp_set_s         = 1'b0;
        // The watchdog counts RUN cycles including the current one, so a
        // transfer gets at most cfg_timeout RUN cycles before it is abandoned.
        wd_inc_s          = wd_cnt_r + TIMEOUT_W'(1);

        case (state_r)
            ST_IDLE: begin
                if (cfg_enable) begin
                    state_nxt_s = ST_SELECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_SELECT: begin
                if (!cfg_enable) begin
                    state_nxt_s = ST_IDLE;
                end else if (owned_r[wr_idx_r]) begin
                    // Consumer still holds this slot: wait in place.
                    if (stall_cnt_r != 16'hFFFF) begin
                        stall_cnt_nxt_s = stall_cnt_r + 16'd1;
                    end else begin
                        stall_cnt_nxt_s = stall_cnt_r;
                    end
                end else begin
                    wr_addr_nxt_s  = buf_addr(cfg_base_addr, cfg_buf_stride, wr_idx_r);
                    wr_start_nxt_s = 1'b1;
                    state_nxt_s    = ST_ARM;
                end
            end

            ST_ARM: begin
                // The writer only leaves idle once stream data shows up, so
                // this wait is unbounded and cfg_enable is deliberately ignored.
                if (bus.wr_busy) begin
                    wr_start_nxt_s = 1'b0;
                    wd_cnt_nxt_s   = {TIMEOUT_W{1'b0}};
                    state_nxt_s    = ST_RUN;
                end else begin
                    wr_start_nxt_s = 1'b1;
                end
            end

            ST_RUN: begin
                wd_cnt_nxt_s = wd_inc_s;
                if (bus.wr_done) begin
                    // Done takes priority over a coincident watchdog expiry.
                    cmp_valid_nxt_s = 1'b1;
                    cmp_idx_nxt_s   = wr_idx_r;
                    state_nxt_s     = ST_COMPLETE;
                end else if ((cfg_timeout != {TIMEOUT_W{1'b0}}) && (wd_inc_s == cfg_timeout)) begin
                    timeout_err_nxt_s = 1'b1;
                    state_nxt_s       = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end

            ST_COMPLETE: begin
                if (cmp_valid_r && bus.cmp_ready) begin
                    cmp_valid_nxt_s = 1'b0;
                    cmp_set_s       = 1'b1;
                    wr_idx_nxt_s    = ring_next(wr_idx_r);
                    state_nxt_s     = ST_SELECT;
                end else begin
                    state_nxt_s = ST_COMPLETE;
                end
            end

            ST_HALT: begin
                wr_start_nxt_s = 1'b0;
                if (!cfg_enable) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end

            default: begin
                state_nxt_s    = ST_IDLE;
                wr_start_nxt_s = 1'b0;
            end
        endcase
    end

    // Ownership tracking: releases and completion sets, checked every cycle.
    always_comb begin
        rel_in_range_s = ({1'b0, bus.rel_idx} < NUM_BUFS_W);
        if (rel_in_range_s) begin
            rel_owned_s = owned_r[bus.rel_idx];
        end else begin
            rel_owned_s = 1'b0;
        end

        if (bus.rel_valid && rel_owned_s) begin
            clr_mask_s = idx_onehot(bus.rel_idx);
        end else begin
            clr_mask_s = {NUM_BUFS{1'b0}};
        end

        if (cmp_set_s) begin
            set_mask_s = idx_onehot(cmp_idx_r);
        end else begin
            set_mask_s = {NUM_BUFS{1'b0}};
        end

        // A release aimed at the slot being completed sees the bit still clear,
        // so it is flagged as an error and the completion's set stands.
        owned_nxt_s   = (owned_r & ~clr_mask_s) | set_mask_s;
        rel_err_nxt_s = rel_err_r | (bus.rel_valid & ~rel_owned_s);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_r       <= ST_IDLE;
            wr_idx_r      <= {IDX_W{1'b0}};
            wr_addr_r     <= {AXI_ADDR_WIDTH{1'b0}};
            wr_start_r    <= 1'b0;
            cmp_valid_r   <= 1'b0;
            cmp_idx_r     <= {IDX_W{1'b0}};
            wd_cnt_r      <= {TIMEOUT_W{1'b0}};
            stall_cnt_r   <= 16'd0;
            timeout_err_r <= 1'b0;
            rel_err_r     <= 1'b0;
            owned_r       <= {NUM_BUFS{1'b0}};
            ctrl_busy_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            wr_idx_r      <= wr_idx_nxt_s;
            wr_addr_r     <= wr_addr_nxt_s;
            wr_start_r    <= wr_start_nxt_s;
            cmp_valid_r   <= cmp_valid_nxt_s;
            cmp_idx_r     <= cmp_idx_nxt_s;
            wd_cnt_r      <= wd_cnt_nxt_s;
            stall_cnt_r   <= stall_cnt_nxt_s;
            timeout_err_r <= timeout_err_nxt_s;
            rel_err_r     <= rel_err_nxt_s;
            owned_r       <= owned_nxt_s;
            ctrl_busy_r   <= (state_nxt_s != ST_IDLE);
        end
    end

    assign bus.wr_base_addr = wr_addr_r;
    assign bus.wr_start     = wr_start_r;
    assign bus.cmp_valid    = cmp_valid_r;
    assign bus.cmp_idx      = cmp_idx_r;
    assign owned_mask       = owned_r;
    assign ctrl_busy        = ctrl_busy_r;
    assign timeout_err      = timeout_err_r;
    assign rel_err          = rel_err_r;
    assign stall_cnt        = stall_cnt_r;

endmodule

// File: tb/tb_axis_s2mm_ring_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axis_s2mm_ring_ctrl
// Scoreboard bench for axis_s2mm_ring_ctrl (NUM_BUFS=4). Expected buffer
// addresses and completion indices are queued when a scenario is set up and
// popped when the controller launches a transfer / completes a handshake.
// A small writer model answers wr_start with busy/done; an optional consumer
// model releases each completed buffer a few cycles after its handshake.
// ---------------------------------------------------------------------------
module tb_axis_s2mm_ring_ctrl;

    localparam logic [31:0] RING_ADDR [4] = '{32'h1000_0000, 32'h1000_0400,
                                              32'h1000_0800, 32'h1000_0C00};

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        cfg_enable;
    logic [31:0] cfg_base_addr;
    logic [31:0] cfg_buf_stride;
    logic [23:0] cfg_timeout;
    logic [3:0]  owned_mask;
    logic        ctrl_busy;
    logic        timeout_err;
    logic        rel_err;
    logic [15:0] stall_cnt;

    axis_s2mm_ring_ctrl_if #(.AXI_ADDR_WIDTH(32), .NUM_BUFS(4)) bus_if ();

    axis_s2mm_ring_ctrl #(
        .AXI_ADDR_WIDTH(32),
        .NUM_BUFS      (4),
        .TIMEOUT_W     (24)
    ) dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .cfg_enable    (cfg_enable),
        .cfg_base_addr (cfg_base_addr),
        .cfg_buf_stride(cfg_buf_stride),
        .cfg_timeout   (cfg_timeout),
        .bus           (bus_if),
        .owned_mask    (owned_mask),
        .ctrl_busy     (ctrl_busy),
        .timeout_err   (timeout_err),
        .rel_err       (rel_err),
        .stall_cnt     (stall_cnt)
    );

    always #5 ACLK = ~ACLK;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_start_cyc = 0;
    logic [31:0] exp_addr_q [$];
    logic [1:0]  exp_idx_q  [$];
    int          rel_when_q [$];
    logic [1:0]  rel_idx_q  [$];
    bit          auto_rel = 1'b0;
    bit          w_hang = 1'b0;
    bit          w_active = 1'b0;
    bit          prev_start = 1'b0;
    int          w_cnt = 0;
    int          busy_delay = 1;
    int          run_len = 4;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: scoreboard on the launch/handshake just seen, then writer and consumer models.
    task automatic step();
        logic       hs;
        logic [1:0] hs_idx;
        hs     = bus_if.cmp_valid && bus_if.cmp_ready;
        hs_idx = bus_if.cmp_idx;
        @(negedge ACLK);
        cyc++;
        if (bus_if.wr_start && !prev_start) begin
            last_start_cyc = cyc;
            check_val("start_expected", 64'(exp_addr_q.size() != 0), 64'd1);
            if (exp_addr_q.size() != 0)
                check_val("wr_base_addr", 64'(bus_if.wr_base_addr), 64'(exp_addr_q.pop_front()));
        end
        prev_start = bus_if.wr_start;
        if (hs) begin
            check_val("cmp_expected", 64'(exp_idx_q.size() != 0), 64'd1);
            if (exp_idx_q.size() != 0)
                check_val("cmp_idx", 64'(hs_idx), 64'(exp_idx_q.pop_front()));
            if (auto_rel) begin
                rel_when_q.push_back(cyc + 4);
                rel_idx_q.push_back(hs_idx);
            end
        end
        // writer model
        if (!ARESETn) begin
            bus_if.wr_busy = 1'b0;
            bus_if.wr_done = 1'b0;
            w_active = 1'b0;
            w_cnt = 0;
        end else begin
            bus_if.wr_done = 1'b0;
            if (!w_active) begin
                if (bus_if.wr_start) begin
                    if (w_cnt >= busy_delay) begin
                        bus_if.wr_busy = 1'b1;
                        w_active = 1'b1;
                        w_cnt = 0;
                    end else begin
                        w_cnt++;
                    end
                end
            end else begin
                w_cnt++;
                if (!w_hang && w_cnt >= run_len) begin
                    bus_if.wr_busy = 1'b0;
                    bus_if.wr_done = 1'b1;
                    w_active = 1'b0;
                    w_cnt = 0;
                end
            end
        end
        // consumer release model
        bus_if.rel_valid = 1'b0;
        if (auto_rel && rel_when_q.size() != 0 && rel_when_q[0] <= cyc) begin
            bus_if.rel_valid = 1'b1;
            bus_if.rel_idx   = rel_idx_q.pop_front();
            void'(rel_when_q.pop_front());
        end
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        cfg_enable = 1'b0;
        bus_if.cmp_ready = 1'b1;
        bus_if.rel_valid = 1'b0;
        bus_if.rel_idx = 2'd0;
        auto_rel = 1'b0;
        w_hang = 1'b0;
        rel_when_q.delete();
        rel_idx_q.delete();
        exp_addr_q.delete();
        exp_idx_q.delete();
        repeat (3) step();
        ARESETn = 1'b1;
        check_val("rst_wr_base_addr", 64'(bus_if.wr_base_addr), 64'd0);
        check_val("rst_wr_start",     64'(bus_if.wr_start), 64'd0);
        check_val("rst_cmp_valid",    64'(bus_if.cmp_valid), 64'd0);
        check_val("rst_cmp_idx",      64'(bus_if.cmp_idx), 64'd0);
        check_val("rst_owned_mask",   64'(owned_mask), 64'd0);
        check_val("rst_timeout_err",  64'(timeout_err), 64'd0);
        check_val("rst_rel_err",      64'(rel_err), 64'd0);
        check_val("rst_stall_cnt",    64'(stall_cnt), 64'd0);
        check_val("rst_ctrl_busy",    64'(ctrl_busy), 64'd0);
    endtask

    task automatic run_until_drained(input int budget);
        int n = 0;
        while ((exp_idx_q.size() != 0 || exp_addr_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check_val("sb_drained", 64'(exp_idx_q.size() + exp_addr_q.size()), 64'd0);
    endtask

    task automatic wait_cmp(input int budget);
        int n = 0;
        while (!bus_if.cmp_valid && n < budget) begin
            step();
            n++;
        end
        check_val("cmp_arrive", 64'(bus_if.cmp_valid), 64'd1);
    endtask

    initial begin
        int n;
        int t0;
        int rel_cyc;
        int s0;
        cfg_base_addr  = 32'h1000_0000;
        cfg_buf_stride = 32'h0000_0400;
        cfg_timeout    = 24'd0;
        bus_if.wr_busy = 1'b0;
        bus_if.wr_done = 1'b0;
        do_reset();

        // Basic ring with a prompt consumer.
        auto_rel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_addr_q.push_back(RING_ADDR[i % 4]);
            exp_idx_q.push_back(2'(i % 4));
        end
        cfg_enable = 1'b1;
        run_until_drained(400);
        cfg_enable = 1'b0;
        repeat (8) step();
        check_val("t1_stall_cnt", 64'(stall_cnt), 64'd0);
        check_val("t1_owned_mask", 64'(owned_mask), 64'd0);
        check_val("t1_idle", 64'(ctrl_busy), 64'd0);

        // No releases: ring fills, then stalls until buffer 0 comes back.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_addr_q.push_back(RING_ADDR[i]);
            exp_idx_q.push_back(2'(i));
        end
        cfg_enable = 1'b1;
        run_until_drained(400);
        repeat (20) step();
        check_val("t2_owned_full", 64'(owned_mask), 64'hF);
        check_val("t2_stall_cnt", 64'(stall_cnt), 64'd20);
        exp_addr_q.push_back(32'h1000_0000);
        exp_idx_q.push_back(2'd0);
        bus_if.rel_valid = 1'b1;
        bus_if.rel_idx = 2'd0;
        rel_cyc = cyc;
        step();
        step();
        check_val("t2_rel_to_start", 64'(last_start_cyc - rel_cyc), 64'd2);
        check_val("t2_stall_final", 64'(stall_cnt), 64'd21);
        run_until_drained(200);
        cfg_enable = 1'b0;
        repeat (2) step();
        check_val("t2_owned_again", 64'(owned_mask), 64'hF);
        check_val("t2_rel_err", 64'(rel_err), 64'd0);

        // Consumer back-pressure: completion held until cmp_ready.
        do_reset();
        auto_rel = 1'b1;
        bus_if.cmp_ready = 1'b0;
        exp_addr_q.push_back(32'h1000_0000);
        exp_idx_q.push_back(2'd0);
        cfg_enable = 1'b1;
        wait_cmp(100);
        for (int i = 0; i < 10; i++) begin
            check_val("t3_cmp_valid_hold", 64'(bus_if.cmp_valid), 64'd1);
            check_val("t3_cmp_idx_hold", 64'(bus_if.cmp_idx), 64'd0);
            check_val("t3_no_start", 64'(bus_if.wr_start), 64'd0);
            check_val("t3_not_owned_yet", 64'(owned_mask), 64'd0);
            step();
        end
        bus_if.cmp_ready = 1'b1;
        cfg_enable = 1'b0;
        step();
        check_val("t3_owned_at_hs", 64'(owned_mask), 64'h1);
        check_val("t3_cmp_valid_clr", 64'(bus_if.cmp_valid), 64'd0);
        repeat (8) step();
        check_val("t3_released", 64'(owned_mask), 64'd0);
        check_val("t3_sb", 64'(exp_idx_q.size()), 64'd0);

        // Watchdog: writer never finishes.
        do_reset();
        w_hang = 1'b1;
        cfg_timeout = 24'd50;
        exp_addr_q.push_back(32'h1000_0000);
        cfg_enable = 1'b1;
        n = 0;
        while ((exp_addr_q.size() != 0 || bus_if.wr_start) && n < 100) begin
            step();
            n++;
        end
        t0 = cyc;
        check_val("t4_no_early_err", 64'(timeout_err), 64'd0);
        n = 0;
        while (!timeout_err && n < 200) begin
            step();
            n++;
        end
        check_val("t4_timeout_latency", 64'(cyc - t0), 64'd50);
        check_val("t4_halt_busy", 64'(ctrl_busy), 64'd1);
        repeat (5) step();
        check_val("t4_halt_stays", 64'(ctrl_busy), 64'd1);
        cfg_enable = 1'b0;
        step();
        check_val("t4_idle", 64'(ctrl_busy), 64'd0);
        check_val("t4_err_sticky", 64'(timeout_err), 64'd1);
        cfg_timeout = 24'd0;

        // Releases: concurrent with another completion, unowned, and same-index.
        do_reset();
        bus_if.cmp_ready = 1'b0;
        exp_addr_q.push_back(RING_ADDR[0]);
        exp_idx_q.push_back(2'd0);
        exp_addr_q.push_back(RING_ADDR[1]);
        exp_idx_q.push_back(2'd1);
        cfg_enable = 1'b1;
        wait_cmp(100);
        bus_if.cmp_ready = 1'b1;
        step();
        bus_if.cmp_ready = 1'b0;
        wait_cmp(100);
        bus_if.cmp_ready = 1'b1;
        bus_if.rel_valid = 1'b1;
        bus_if.rel_idx = 2'd0;
        cfg_enable = 1'b0;
        step();
        check_val("t5_both_apply", 64'(owned_mask), 64'h2);
        check_val("t5_good_rel", 64'(rel_err), 64'd0);
        bus_if.rel_valid = 1'b1;
        bus_if.rel_idx = 2'd2;
        step();
        check_val("t5_unowned_err", 64'(rel_err), 64'd1);
        check_val("t5_mask_kept", 64'(owned_mask), 64'h2);
        bus_if.rel_valid = 1'b1;
        bus_if.rel_idx = 2'd1;
        step();
        check_val("t5_rel_clears", 64'(owned_mask), 64'h0);
        do_reset();
        bus_if.cmp_ready = 1'b0;
        exp_addr_q.push_back(RING_ADDR[0]);
        exp_idx_q.push_back(2'd0);
        cfg_enable = 1'b1;
        wait_cmp(100);
        bus_if.cmp_ready = 1'b1;
        bus_if.rel_valid = 1'b1;
        bus_if.rel_idx = 2'd0;
        cfg_enable = 1'b0;
        step();
        check_val("t5_same_idx_err", 64'(rel_err), 64'd1);
        check_val("t5_same_idx_set", 64'(owned_mask), 64'h1);

        // Address wrap past 2^32.
        do_reset();
        auto_rel = 1'b1;
        cfg_base_addr = 32'hFFFF_F800;
        cfg_buf_stride = 32'h0000_0400;
        exp_addr_q.push_back(32'hFFFF_F800);
        exp_idx_q.push_back(2'd0);
        exp_addr_q.push_back(32'hFFFF_FC00);
        exp_idx_q.push_back(2'd1);
        exp_addr_q.push_back(32'h0000_0000);
        exp_idx_q.push_back(2'd2);
        cfg_enable = 1'b1;
        run_until_drained(400);
        cfg_enable = 1'b0;
        repeat (8) step();
        check_val("t6_owned_clear", 64'(owned_mask), 64'd0);

        // Disable in SELECT, then resume at the retained slot (3).
        cfg_enable = 1'b1;
        step();
        check_val("t7_in_select", 64'(ctrl_busy), 64'd1);
        s0 = last_start_cyc;
        cfg_enable = 1'b0;
        step();
        check_val("t7_back_idle", 64'(ctrl_busy), 64'd0);
        repeat (3) step();
        check_val("t7_no_start", 64'(last_start_cyc - s0), 64'd0);
        exp_addr_q.push_back(32'h0000_0400);
        exp_idx_q.push_back(2'd3);
        cfg_enable = 1'b1;
        run_until_drained(200);
        cfg_enable = 1'b0;
        repeat (8) step();

        check_val("sb_final", 64'(exp_addr_q.size() + exp_idx_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
